// File: rtl/dmem_lsu_if.sv
// Pipeline-side request/response bundle for the data-memory load/store unit.
// master = MEM stage issuing requests, slave = dmem_lsu.
interface dmem_lsu_if #(
  parameter int DWL = 32,
  parameter int AWL = 9
);
  logic           req_valid;
  logic           req_ready;
  logic           req_we;
  logic [1:0]     req_size;
  logic           req_sgn;
  logic [AWL+1:0] req_addr;
  logic [DWL-1:0] req_wdata;
  logic           done;
  logic [DWL-1:0] rdata;
  logic           err;

  modport master (
    output req_valid, req_we, req_size,
    output req_sgn, req_addr, req_wdata,
    input  req_ready, done, rdata, err
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_sgn, req_addr, req_wdata,
    output req_ready, done, rdata, err
  );
endinterface

// File: rtl/dmem_lsu.sv
// MEM-stage load/store initiator; sub-word stores are read-modify-write.
// Optional MISALIGN_TRAP_EN: misaligned half/word skip memory and flag err.
module dmem_lsu #(
  parameter int DWL = 32,
  parameter int AWL = 9
) (
  input  logic           CLK,
  input  logic           RSTN,
  dmem_lsu_if.slave      bus,
  output logic [AWL-1:0] DMA,
  output logic [DWL-1:0] DMWD,
  output logic           DMWE,
  input  logic [DWL-1:0] DMRD
);

  typedef enum logic [1:0] {
    IDLE, ACCESS, WRITE, DONE
  } state_t;

  state_t         state, state_n;
  logic           we_q;
  logic [1:0]     size_q;
  logic           sgn_q;
  logic [AWL+1:0] addr_q;
  logic [DWL-1:0] wdata_q;
  logic [DWL-1:0] merge_q;
  logic [DWL-1:0] rdata_q;

  logic           is_byte, is_half, is_word;
  logic           mis;
  logic [1:0]     lane;
  logic [4:0]     sh;
  logic [DWL-1:0] shifted;
  logic [DWL-1:0] ld_val;
  logic [DWL-1:0] bmask;
  logic [DWL-1:0] ins;
  logic [DWL-1:0] merged;

  assign is_byte = (size_q == 2'b00);
  assign is_half = (size_q == 2'b01);
  assign is_word = size_q[1];

`ifdef MISALIGN_TRAP_EN
  assign mis = (is_half & addr_q[0])
             | (is_word & |addr_q[1:0]);
`else
  assign mis = 1'b0;
`endif

  // Half lane ignores addr[0]; words always use lane 0.
  assign lane    = is_half ? {addr_q[1], 1'b0}
                 : is_byte ? addr_q[1:0] : 2'b00;
  assign sh      = {lane, 3'b000};
  assign shifted = DMRD >> sh;

  always_comb begin
    ld_val = DMRD;
    unique case (1'b1)
      is_byte: ld_val = {{(DWL-8){sgn_q & shifted[7]}},
                         shifted[7:0]};
      is_half: ld_val = {{(DWL-16){sgn_q & shifted[15]}},
                         shifted[15:0]};
      is_word: ld_val = DMRD;
      default: ld_val = DMRD;
    endcase
  end

  always_comb begin
    bmask = '0;
    ins   = '0;
    unique case (1'b1)
      is_byte: begin
        bmask = DWL'(8'hFF) << sh;
        ins   = DWL'(wdata_q[7:0]) << sh;
      end
      is_half: begin
        bmask = DWL'(16'hFFFF) << sh;
        ins   = DWL'(wdata_q[15:0]) << sh;
      end
      is_word: begin
        bmask = '1;
        ins   = wdata_q;
      end
      default: begin
        bmask = '1;
        ins   = wdata_q;
      end
    endcase
    merged = (merge_q & ~bmask) | (ins & bmask);
  end

  // Memory port decodes from state and latched request only.
  assign DMA  = addr_q[AWL+1:2];
  assign DMWE = (state == WRITE)
              | ((state == ACCESS) & we_q & is_word & ~mis);
  assign DMWD = DMWE ? merged : '0;

  assign bus.req_ready = (state == IDLE);
  assign bus.done      = (state == DONE);
  assign bus.err       = (state == DONE) & mis;
  assign bus.rdata     = rdata_q;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (bus.req_valid) state_n = ACCESS;
      ACCESS: begin
        if (!mis && we_q && !is_word) state_n = WRITE;
        else                          state_n = DONE;
      end
      WRITE:  state_n = DONE;
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.req_valid) begin
        we_q    <= bus.req_we;
        size_q  <= bus.req_size;
        sgn_q   <= bus.req_sgn;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (state == ACCESS && !mis) begin
        if (!we_q)         rdata_q <= ld_val;
        else if (!is_word) merge_q <= DMRD;
      end
    end
  end

endmodule
